id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode pipeline stage, directly downstream of the fetch stage.
- Latches {pc, inst} from fetch through the valid/allowin handshake and reads the register file.
- Detects RAW hazards against in-flight destinations, predicts control flow and returns the prediction to fetch as br_info.
- Forwards a packed decode bundle to the execute stage.

Parameters:
IF_TO_ID_DATA_WD, 64, fetch bundle width: {pc[63:32], inst[31:0]}
BR_WD, 33, prediction bundle width: {br_go, br_target}
ID_TO_EXE_DATA_WD, 167, execute bundle width (layout below)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_to_id_valid  in  1  fetch presents a valid bundle
if_to_id_data  in  64  {pc, inst}
id_allowin  out  1  ID can accept a bundle this cycle
br_info  out  33  prediction to fetch: {br_go, br_target}
cancle  in  1  flush from execute (mispredict)
rf_raddr1  out  5  register-file read address 1
rf_rdata1  in  32  combinational read data 1
rf_raddr2  out  5  register-file read address 2
rf_rdata2  in  32  combinational read data 2
exe_dest  in  6  {we, rd} of the instruction in EXE
mem_dest  in  6  {we, rd} of the instruction in MEM
wb_dest  in  6  {we, rd} of the instruction in WB
exe_allowin  in  1  execute can accept
id_to_exe_valid  out  1  bundle valid to execute
id_to_exe_data  out  167  {pc[166:135], inst[134:103], rs1_val[102:71], rs2_val[70:39], rd[38:34], rf_we[33], pred_taken[32], pred_target[31:0]}
Stall_cnt  out  32  performance counter: hazard-stall cycles

Behaviour:
- Reset: id_valid=0 and Stall_cnt=0. With id_valid=0: id_allowin=1, id_to_exe_valid=0, br_go=0. Pipeline data registers are not reset.
- Handshake:
  - id_allowin = !id_valid || (id_ready_go && exe_allowin).
  - id_ready_go = !hazard.
  - id_to_exe_valid = id_valid && id_ready_go && !cancle.
- Valid update: when cancle=1, id_valid<=0. cancle has priority over any load in the same cycle. Otherwise, when id_allowin=1, id_valid<=if_to_id_valid.
- Data latch: {pc, inst} is loaded when if_to_id_valid && id_allowin && !cancle. Otherwise it holds.
- Decode, combinational from the latched inst:
  - rf_raddr1=inst[19:15], rf_raddr2=inst[24:20], rd=inst[11:7].
  - rs1 is used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used by BRANCH (1100011), STORE (0100011) and OP (0110011).
  - rf_we=0 for BRANCH, STORE, or rd=0. Otherwise rf_we=1.
- Hazard: asserted when id_valid and any used rs is non-zero and equals the rd of an exe/mem/wb dest whose we=1. While hazard=1, the instruction holds in ID and id_allowin=0 regardless of exe_allowin.
- Prediction:
  - JAL: pred_taken=1, target = pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - BRANCH: pred_taken per the optional feature; B-type target = pc + sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - JALR and all other opcodes: pred_taken=0.
  - When pred_taken=0, pred_target=pc+4.
  - All additions are 32-bit with wrap-around; carry is discarded.
- br_info = {id_valid && pred_taken && !cancle, pred_target}. It is stable for the whole time the instruction stays in ID, including hazard stalls. Fetch samples it when its own handshake completes.
- Stall_cnt increments by 1 each cycle with id_valid && hazard && !cancle. It wraps at 2^32.
- rst mid-stall drops the instruction and zeroes the counter in the next cycle.
- cancle during a stall drops the instruction. The next fetch bundle may load in the following cycle.

Optional Feature:
- Macro ID_BTFN_PREDICT_EN.
- Defined: a BRANCH with inst[31]=1 (backward, negative offset) is predicted taken. A BRANCH with inst[31]=0 is predicted not taken.
- Undefined: every BRANCH is predicted not taken (pred_taken=0, target pc+4). JAL behaviour is unchanged.

Test Plan:
- Reset, then idle: rst high 2 cycles → id_valid=0, id_allowin=1, id_to_exe_valid=0, br_info=0 (br_go=0), Stall_cnt=0.
- Pass-through: pc=0x100, inst=ADDI x1,x2,5 (0x00510093), exe_allowin=1 → next cycle id_to_exe_valid=1, rd=1, rf_we=1, pred_target=0x104, pred_taken=0.
- Hazard: inst=ADD x3,x1,x2 (0x002081B3) with exe_dest={1,1} for 2 cycles then {0,0} → id_allowin=0 and id_to_exe_valid=0 for 2 cycles, then released. Stall_cnt=2. Repeat with exe_dest={1,0} (x0 write) → no stall.
- JAL: pc=0x200, inst=JAL x0,-8 (0xFF9FF06F) → br_info={1, 0x1F8}. Same cycle with cancle=1 → br_go=0 and id_valid=0 next cycle.
- BTFN: pc=0x300, inst=BEQ x1,x2,-16 (0xFE2088E3) → with ID_BTFN_PREDICT_EN: br_info={1, 0x2F0}. Without it: {0, 0x304}.
- Back-pressure: exe_allowin=0 with a valid, hazard-free instruction → id_allowin=0, data and br_info held unchanged, Stall_cnt not incremented.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: latches the fetch bundle, detects RAW hazards, predicts control flow.
// Optional backward-taken/forward-not-taken branch prediction via `define ID_BTFN_PREDICT_EN.
module id_stage #(
    parameter int IF_TO_ID_DATA_WD  = 64,
    parameter int BR_WD             = 33,
    parameter int ID_TO_EXE_DATA_WD = 167
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_to_id_valid,
    input  logic [IF_TO_ID_DATA_WD-1:0]  if_to_id_data,
    output logic                         id_allowin,
    output logic [BR_WD-1:0]             br_info,
    input  logic                         cancle,
    output logic [4:0]                   rf_raddr1,
    input  logic [31:0]                  rf_rdata1,
    output logic [4:0]                   rf_raddr2,
    input  logic [31:0]                  rf_rdata2,
    input  logic [5:0]                   exe_dest,
    input  logic [5:0]                   mem_dest,
    input  logic [5:0]                   wb_dest,
    input  logic                         exe_allowin,
    output logic                         id_to_exe_valid,
    output logic [ID_TO_EXE_DATA_WD-1:0] id_to_exe_data,
    output logic [31:0]                  Stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic        id_valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic [31:0] stall_cnt_reg;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        rf_we;
    logic        hazard;
    logic        id_ready_go;
    logic        load_en;
    logic [2:0]  rs1_hit;
    logic [2:0]  rs2_hit;
    logic [5:0]  dest_arr [3];
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] jal_imm;
    logic [31:0] br_imm;

    assign opcode = inst_reg[6:0];
    assign rs1    = inst_reg[19:15];
    assign rs2    = inst_reg[24:20];
    assign rd     = inst_reg[11:7];

    assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign rs2_used = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);
    assign rf_we    = !((opcode == OP_BRANCH) || (opcode == OP_STORE)) && (rd != 5'd0);

    assign dest_arr[0] = exe_dest;
    assign dest_arr[1] = mem_dest;
    assign dest_arr[2] = wb_dest;

    // One comparator pair per in-flight stage; bit 5 of each dest is its write enable.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dest_cmp
            assign rs1_hit[gi] = dest_arr[gi][5] && (dest_arr[gi][4:0] == rs1);
            assign rs2_hit[gi] = dest_arr[gi][5] && (dest_arr[gi][4:0] == rs2);
        end
    endgenerate

    assign hazard = id_valid_reg &&
                    ((rs1_used && (rs1 != 5'd0) && (|rs1_hit)) ||
                     (rs2_used && (rs2 != 5'd0) && (|rs2_hit)));

    assign id_ready_go     = !hazard;
    assign id_allowin      = !id_valid_reg || (id_ready_go && exe_allowin);
    assign id_to_exe_valid = id_valid_reg && id_ready_go && !cancle;
    assign load_en         = if_to_id_valid && id_allowin && !cancle;

    assign jal_imm = {{11{inst_reg[31]}}, inst_reg[31], inst_reg[19:12], inst_reg[20],
                      inst_reg[30:21], 1'b0};
    assign br_imm  = {{19{inst_reg[31]}}, inst_reg[31], inst_reg[7], inst_reg[30:25],
                      inst_reg[11:8], 1'b0};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_reg + 32'd4;
        if (opcode == OP_JAL) begin
            pred_taken  = 1'b1;
            pred_target = pc_reg + jal_imm;
        end
`ifdef ID_BTFN_PREDICT_EN
        else if ((opcode == OP_BRANCH) && inst_reg[31]) begin
            pred_taken  = 1'b1;
            pred_target = pc_reg + br_imm;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_reg <= 1'b0;
        end else if (cancle) begin
            id_valid_reg <= 1'b0;
        end else if (id_allowin) begin
            id_valid_reg <= if_to_id_valid;
        end
    end

    // Bundle registers carry no reset; id_valid_reg qualifies them.
    always_ff @(posedge clk) begin
        if (load_en) begin
            pc_reg   <= if_to_id_data[63:32];
            inst_reg <= if_to_id_data[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= 32'd0;
        end else if (hazard && !cancle) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;
    assign br_info   = {id_valid_reg && pred_taken && !cancle, pred_target};
    assign Stall_cnt = stall_cnt_reg;

    assign id_to_exe_data = {pc_reg, inst_reg, rf_rdata1, rf_rdata2, rd, rf_we,
                             pred_taken, pred_target};

`ifdef ID_BTFN_PREDICT_EN
`else
    // br_imm only feeds the taken-branch path; keep it referenced in the default build.
    logic unused_br_imm;
    assign unused_br_imm = ^br_imm;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed steps followed by randomized traffic,
// checked against a behavioural model of the decode stage.
module tb_id_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_to_id_valid;
    logic [63:0]  if_to_id_data;
    logic         id_allowin;
    logic [32:0]  br_info;
    logic         cancle;
    logic [4:0]   rf_raddr1;
    logic [31:0]  rf_rdata1;
    logic [4:0]   rf_raddr2;
    logic [31:0]  rf_rdata2;
    logic [5:0]   exe_dest;
    logic [5:0]   mem_dest;
    logic [5:0]   wb_dest;
    logic         exe_allowin;
    logic         id_to_exe_valid;
    logic [166:0] id_to_exe_data;
    logic [31:0]  Stall_cnt;

    always #5 clk = ~clk;

    id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .if_to_id_valid  (if_to_id_valid),
        .if_to_id_data   (if_to_id_data),
        .id_allowin      (id_allowin),
        .br_info         (br_info),
        .cancle          (cancle),
        .rf_raddr1       (rf_raddr1),
        .rf_rdata1       (rf_rdata1),
        .rf_raddr2       (rf_raddr2),
        .rf_rdata2       (rf_rdata2),
        .exe_dest        (exe_dest),
        .mem_dest        (mem_dest),
        .wb_dest         (wb_dest),
        .exe_allowin     (exe_allowin),
        .id_to_exe_valid (id_to_exe_valid),
        .id_to_exe_data  (id_to_exe_data),
        .Stall_cnt       (Stall_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model of the instruction sitting in ID.
    bit          m_known = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_inst  = 32'd0;
    logic [31:0] m_stall = 32'd0;

    logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0100011, 7'b0110011, 7'b0010011, 7'b0000011};

    task automatic chk(input string tag, input logic [166:0] obs, input logic [166:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b1100011, 7'b0100011, 7'b0110011};
    endfunction

    function automatic bit writes_reg(input logic [5:0] d, input logic [4:0] r);
        return d[5] && (r != 5'd0) && (d[4:0] == r);
    endfunction

    function automatic bit m_hazard();
        logic [6:0] op;
        logic [4:0] s1;
        logic [4:0] s2;
        bit h1;
        bit h2;
        op = m_inst[6:0];
        s1 = m_inst[19:15];
        s2 = m_inst[24:20];
        h1 = reads_rs1(op) && (writes_reg(exe_dest, s1) || writes_reg(mem_dest, s1) ||
                               writes_reg(wb_dest, s1));
        h2 = reads_rs2(op) && (writes_reg(exe_dest, s2) || writes_reg(mem_dest, s2) ||
                               writes_reg(wb_dest, s2));
        return m_valid && (h1 || h2);
    endfunction

    function automatic bit m_rf_we();
        logic [6:0] op;
        op = m_inst[6:0];
        return !(op inside {7'b1100011, 7'b0100011}) && (m_inst[11:7] != 5'd0);
    endfunction

    function automatic void m_predict(output bit taken, output logic [31:0] tgt);
        logic signed [20:0] jimm;
        logic signed [12:0] bimm;
        int off;
        jimm  = {m_inst[31], m_inst[19:12], m_inst[20], m_inst[30:21], 1'b0};
        bimm  = {m_inst[31], m_inst[7], m_inst[30:25], m_inst[11:8], 1'b0};
        taken = 1'b0;
        tgt   = m_pc + 32'd4;
        if (m_inst[6:0] == 7'b1101111) begin
            off   = jimm;
            taken = 1'b1;
            tgt   = m_pc + 32'(off);
        end
`ifdef ID_BTFN_PREDICT_EN
        if ((m_inst[6:0] == 7'b1100011) && (bimm < 0)) begin
            off   = bimm;
            taken = 1'b1;
            tgt   = m_pc + 32'(off);
        end
`endif
    endfunction

    task automatic drive(input bit iv, input logic [31:0] pc, input logic [31:0] inst,
                         input bit can, input bit ea, input logic [5:0] ed,
                         input logic [5:0] md, input logic [5:0] wd, input bit r);
        if_to_id_valid = iv;
        if_to_id_data  = {pc, inst};
        cancle         = can;
        exe_allowin    = ea;
        exe_dest       = ed;
        mem_dest       = md;
        wb_dest        = wd;
        rst            = r;
        rf_rdata1      = $urandom;
        rf_rdata2      = $urandom;
        #1;
    endtask

    // Check every output against the model, clock once, then advance the model.
    task automatic tick();
        bit          hz;
        bit          tk;
        bit          allow;
        logic [31:0] tg;
        hz    = m_hazard();
        m_predict(tk, tg);
        allow = !m_valid || (!hz && exe_allowin);
        if (m_known) begin
            chk("allowin", id_allowin, allow);
            chk("exe_valid", id_to_exe_valid, m_valid && !hz && !cancle);
            chk("br_go", br_info[32], m_valid && tk && !cancle);
            chk("stall_cnt", Stall_cnt, m_stall);
            if (m_valid) begin
                chk("br_target", br_info[31:0], tg);
                chk("raddr", {rf_raddr1, rf_raddr2}, {m_inst[19:15], m_inst[24:20]});
                chk("exe_data", id_to_exe_data,
                    {m_pc, m_inst, rf_rdata1, rf_rdata2, m_inst[11:7], m_rf_we(), tk, tg});
            end
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_stall = 32'd0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (hz && !cancle) m_stall = m_stall + 32'd1;
            if (if_to_id_valid && allow && !cancle) begin
                m_pc   = if_to_id_data[63:32];
                m_inst = if_to_id_data[31:0];
            end
            if (cancle) m_valid = 1'b0;
            else if (allow) m_valid = if_to_id_valid;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ri;
        @(negedge clk);

        // Reset for two cycles, then idle.
        drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("rst_allowin", id_allowin, 1'b1);
        chk("rst_exe_valid", id_to_exe_valid, 1'b0);
        chk("rst_br_go", br_info[32], 1'b0);
        chk("rst_stall", Stall_cnt, 32'd0);
        tick();

        // Pass-through of ADDI x1,x2,5.
        drive(1, 32'h100, 32'h00510093, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("pass_valid", id_to_exe_valid, 1'b1);
        chk("pass_rd", id_to_exe_data[38:34], 5'd1);
        chk("pass_we", id_to_exe_data[33], 1'b1);
        chk("pass_taken", id_to_exe_data[32], 1'b0);
        chk("pass_target", id_to_exe_data[31:0], 32'h104);
        tick();

        // ADD x3,x1,x2 stalled two cycles by x1 in EXE.
        drive(1, 32'h110, 32'h002081B3, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1, 6'b100001, 0, 0, 0);
            chk("haz_allowin", id_allowin, 1'b0);
            chk("haz_exe_valid", id_to_exe_valid, 1'b0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("haz_release", id_to_exe_valid, 1'b1);
        chk("haz_stall_cnt", Stall_cnt, 32'd2);
        tick();

        // A write to x0 never blocks.
        drive(1, 32'h120, 32'h002081B3, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 6'b100000, 0, 0, 0);
        chk("x0_no_stall", id_to_exe_valid, 1'b1);
        tick();

        // JAL x0,-8 at 0x200, then cancelled in the same cycle.
        drive(1, 32'h200, 32'hFF9FF06F, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_br_info", br_info, 33'h1_0000_01F8);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("jal_cancel_go", br_info[32], 1'b0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("jal_dropped", id_to_exe_valid, 1'b0);
        tick();

        // BEQ x1,x2,-16 at 0x300.
        drive(1, 32'h300, 32'hFE2088E3, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ID_BTFN_PREDICT_EN
        chk("btfn_br_info", br_info, 33'h1_0000_02F0);
`else
        chk("btfn_br_info", br_info, 33'h0_0000_0304);
`endif
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick();

        // Back-pressure holds a hazard-free instruction without counting stalls.
        drive(1, 32'h400, 32'h00510093, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h500, 32'h00000013, 0, 0, 0, 0, 0, 0);
            chk("bp_allowin", id_allowin, 1'b0);
            chk("bp_pc", id_to_exe_data[166:135], 32'h400);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("bp_stall_cnt", Stall_cnt, 32'd2);
        tick();

        // Randomized traffic with a small register pool to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            ri        = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 8)];
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            ri[11:7]  = 5'($urandom_range(0, 3));
            drive(bit'($urandom_range(0, 1)), $urandom, ri,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))},
                  {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))},
                  {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))},
                  ($urandom_range(0, 39) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
